// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths.
// Holds the per-direction state types, counter widths and default
// frame parameters. No ports.
package uart_pkg;

  // Defaults shared by both directions.
  localparam int unsigned D_W_DEF    = 8;
  localparam int unsigned B_TICK_DEF = 16;

  // Bit counter is wide enough for up to 9 data bits and 2 stop bits.
  localparam int unsigned BIT_CNT_W = 4;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_LOAD,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // Width of an oversample tick counter that wraps at b_tick.
  function automatic int unsigned tick_cnt_w(input int unsigned b_tick);
    return (b_tick > 1) ? $clog2(b_tick) : 1;
  endfunction

endpackage

// File: rtl/uart_tick_cnt.sv
// Oversample tick counter: counts baud_clk ticks within one bit period
// and flags the last tick of the period. Shared by TX and RX.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   clear_i       hold the counter at zero (ticks ignored)
//   baud_clk_i    one-clk oversample tick
//   done_c_o      combinational: last tick of the bit period (count==B_TICK-1 on a tick)
module uart_tick_cnt
  import uart_pkg::*;
#(
  parameter int unsigned B_TICK = B_TICK_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic baud_clk_i,
  output logic done_c_o
);

  localparam int unsigned CNT_W = tick_cnt_w(B_TICK);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count ticks; the power-of-two period lets the counter wrap by itself.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (baud_clk_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_c_o = baud_clk_i && !clear_i && (cnt_q == CNT_W'(B_TICK - 1));

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pops bytes from the TX FIFO and serialises each as
// start bit, D_W data bits LSB first, optional even parity, STOP_BITS stop bits.
// Build option: define UART_TX_PARITY_EN to insert the even parity bit.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   baud_clk     oversample tick, B_TICK per bit
//   baud_en      baud generator enable while a frame is in progress
//   tx_data      serial line, idles high, driven from a flop
//   tx_busy      high from FIFO pop until the end of the last stop bit
//   in_data      FIFO read data
//   ff_empty     FIFO empty flag
//   ff_rd_en     single-cycle FIFO pop strobe
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned D_W       = D_W_DEF,
  parameter int unsigned B_TICK    = B_TICK_DEF,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           baud_clk,
  output logic           baud_en,
  output logic           tx_data,
  output logic           tx_busy,
  input  logic [D_W-1:0] in_data,
  input  logic           ff_empty,
  output logic           ff_rd_en
);

  tx_state_e              state_q, state_d;
  logic [D_W-1:0]         shift_q, shift_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic                   tx_data_q, tx_data_d;
  logic                   baud_en_q, baud_en_d;
  logic                   busy_q, busy_d;
  logic                   rd_en_q, rd_en_d;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  logic tick_clear_c;
  logic tick_done_c;

  // Ticks only count while a bit is on the line.
  assign tick_clear_c = (state_q == TX_IDLE) || (state_q == TX_LOAD);

  uart_tick_cnt #(
    .B_TICK(B_TICK)
  ) u_tick_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (tick_clear_c),
    .baud_clk_i(baud_clk),
    .done_c_o  (tick_done_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    baud_en_d = baud_en_q;
    busy_d    = busy_q;
    rd_en_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      // Also the pop cycle between back-to-back frames, where busy and
      // baud_en are still held high from the previous frame.
      TX_IDLE: begin
        if (!ff_empty) begin
          rd_en_d = 1'b1;
          busy_d  = 1'b1;
          state_d = TX_LOAD;
        end else begin
          busy_d    = 1'b0;
          baud_en_d = 1'b0;
        end
      end
      TX_LOAD: begin
        shift_d   = in_data;
        bit_cnt_d = '0;
        baud_en_d = 1'b1;
`ifdef UART_TX_PARITY_EN
        parity_d  = ^in_data;
`endif
        state_d   = TX_START;
      end
      TX_START: begin
        if (tick_done_c) begin
          bit_cnt_d = '0;
          state_d   = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tick_done_c) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BIT_CNT_W'(D_W - 1)) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = TX_PARITY;
`else
            state_d   = TX_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      TX_PARITY: begin
        if (tick_done_c) begin
          bit_cnt_d = '0;
          state_d   = TX_STOP;
        end
      end
`endif
      TX_STOP: begin
        if (tick_done_c) begin
          if (bit_cnt_q == BIT_CNT_W'(STOP_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = TX_IDLE;
            // Keep the generator and busy up if another byte is waiting.
            if (ff_empty) begin
              busy_d    = 1'b0;
              baud_en_d = 1'b0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = TX_IDLE;
      end
    endcase

    // Line level follows the state being entered so it is registered glitch-free.
    case (state_d)
      TX_START:  tx_data_d = 1'b0;
      TX_DATA:   tx_data_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      TX_PARITY: tx_data_d = parity_d;
`endif
      default:   tx_data_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= TX_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_data_q <= 1'b1;
      baud_en_q <= 1'b0;
      busy_q    <= 1'b0;
      rd_en_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_data_q <= tx_data_d;
      baud_en_q <= baud_en_d;
      busy_q    <= busy_d;
      rd_en_q   <= rd_en_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign tx_data  = tx_data_q;
  assign baud_en  = baud_en_q;
  assign tx_busy  = busy_q;
  assign ff_rd_en = rd_en_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: reset, single frames, back-to-back frames,
// mid-frame reset and a two-stop-bit instance. Honors UART_TX_PARITY_EN.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic       clk, rst_n, baud_clk;
  logic       baud_en, tx_data, tx_busy, ff_empty, ff_rd_en;
  logic [7:0] in_data;
  logic       baud_en2, tx_data2, tx_busy2, ff_empty2, ff_rd_en2;
  logic [7:0] in_data2;

  uart_tx u_dut (
    .clk(clk), .rst_n(rst_n), .baud_clk(baud_clk), .baud_en(baud_en),
    .tx_data(tx_data), .tx_busy(tx_busy), .in_data(in_data),
    .ff_empty(ff_empty), .ff_rd_en(ff_rd_en)
  );

  uart_tx #(.STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .baud_clk(baud_clk), .baud_en(baud_en2),
    .tx_data(tx_data2), .tx_busy(tx_busy2), .in_data(in_data2),
    .ff_empty(ff_empty2), .ff_rd_en(ff_rd_en2)
  );

  int total = 0;
  int bad   = 0;

  // Monitor state, sampled 1 time unit after each rising edge.
  logic [7:0] fifo[$];
  int   edges[$];
  int   edges2[$];
  int   rd_cyc[$];
  int   cyc = 0;
  int   rd_cnt = 0, rd2_cnt = 0;
  int   empty_fall = -1, busy_fall = -1, busy2_fall = -1;
  int   baud_gap = 0;
  logic tx_prev = 1'b1, tx2_prev = 1'b1, busy_prev = 1'b0, busy2_prev = 1'b0;
  logic pend_pop = 1'b0, prev_empty;

  // Expected edge offsets relative to the rising edge that starts data bit 0.
`ifdef UART_TX_PARITY_EN
  int offs_a5[10] = '{0, 64, 128, 192, 320, 384, 448, 512, 576, 0};
  localparam int N_A5 = 9;
`else
  int offs_a5[10] = '{0, 64, 128, 192, 320, 384, 448, 0, 0, 0};
  localparam int N_A5 = 7;
`endif
  int offs_07[10] = '{0, 192, 512, 0, 0, 0, 0, 0, 0, 0};
  int offs_03[10] = '{0, 128, 512 + 64 * PB, 0, 0, 0, 0, 0, 0, 0};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Baud tick: one clk wide, every 4 clk.
  initial begin
    baud_clk = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 baud_clk = 1'b1;
      @(posedge clk);
      #1 baud_clk = 1'b0;
    end
  end

  // FIFO model plus event recorder for both DUTs.
  initial begin
    ff_empty = 1'b1;
    in_data  = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (pend_pop) begin
        if (fifo.size() > 0) fifo.delete(0);
        pend_pop = 1'b0;
      end
      if (ff_rd_en === 1'b1) pend_pop = 1'b1;
      prev_empty = ff_empty;
      ff_empty   = (fifo.size() == 0);
      in_data    = (fifo.size() > 0) ? fifo[0] : 8'h00;
      cyc++;
      if (prev_empty && !ff_empty) empty_fall = cyc;
      if (ff_rd_en === 1'b1) begin
        rd_cnt++;
        rd_cyc.push_back(cyc);
      end
      if (ff_rd_en2 === 1'b1) rd2_cnt++;
      if (tx_data !== tx_prev) begin
        edges.push_back(cyc);
        tx_prev = tx_data;
      end
      if (tx_data2 !== tx2_prev) begin
        edges2.push_back(cyc);
        tx2_prev = tx_data2;
      end
      if (busy_prev && !tx_busy) busy_fall = cyc;
      if (busy2_prev && !tx_busy2) busy2_fall = cyc;
      busy_prev  = tx_busy;
      busy2_prev = tx_busy2;
      if (tx_busy && !baud_en && edges.size() > 0) baud_gap++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int edge_at(input int i);
    return (i < edges.size()) ? edges[i] : -1;
  endfunction

  function automatic int edge2_at(input int i);
    return (i < edges2.size()) ? edges2[i] : -1;
  endfunction

  function automatic int rd_at(input int i);
    return (i < rd_cyc.size()) ? rd_cyc[i] : -1;
  endfunction

  task automatic wait_busy_fall(input string tag);
    int n;
    n = 0;
    while (busy_fall < 0 && n < 4000) begin
      @(posedge clk);
      n++;
    end
    chk({tag, "_timeout"}, 32'(busy_fall >= 0), 32'd1);
  endtask

  task automatic wait_edges(input string tag, input int cnt);
    int n;
    n = 0;
    while (edges.size() < cnt && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk({tag, "_timeout"}, 32'(edges.size() >= cnt), 32'd1);
  endtask

  task automatic clear_trackers();
    edges.delete();
    rd_cyc.delete();
    rd_cnt     = 0;
    busy_fall  = -1;
    empty_fall = -1;
    baud_gap   = 0;
  endtask

  // Single frame from idle; byte bit 0 must be 1 so edge 1 starts data bit 0.
  task automatic send_single(input string tag, input logic [7:0] b, input int n,
                             input int offs[10], input int busy_off);
    int b1, slen;
    @(posedge clk);
    #5;
    clear_trackers();
    fifo.push_back(b);
    wait_busy_fall(tag);
    repeat (4) @(posedge clk);
    #5;
    b1   = edge_at(1);
    slen = b1 - edge_at(0);
    chk({tag, "_pops"}, 32'(rd_cnt), 32'd1);
    chk({tag, "_latency"}, 32'(edge_at(0) - empty_fall), 32'd2);
    chk({tag, "_start_len"}, 32'(slen >= 61 && slen <= 64), 32'd1);
    chk({tag, "_edge_cnt"}, 32'(edges.size()), 32'(n + 1));
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_edge%0d", tag, i), 32'(edge_at(i + 1) - b1), 32'(offs[i]));
    end
    chk({tag, "_busy_end"}, 32'(busy_fall - b1), 32'(busy_off));
  endtask

  initial begin
    int n, p, s2;
    rst_n     = 1'b0;
    ff_empty2 = 1'b1;
    in_data2  = 8'h55;

    // Reset values.
    repeat (3) @(posedge clk);
    #3;
    chk("rst_tx", 32'(tx_data), 32'd1);
    chk("rst_baud_en", 32'(baud_en), 32'd0);
    chk("rst_rd_en", 32'(ff_rd_en), 32'd0);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_tx2", 32'(tx_data2), 32'd1);
    rst_n = 1'b1;

    // Idle with an empty FIFO: no pop, line high.
    clear_trackers();
    repeat (1000) @(posedge clk);
    #5;
    chk("idle_pops", 32'(rd_cnt), 32'd0);
    chk("idle_edges", 32'(edges.size()), 32'd0);
    chk("idle_tx", 32'(tx_data), 32'd1);

    // Single frames.
    send_single("a5", 8'hA5, N_A5, offs_a5, 576 + 64 * PB);
    send_single("x07", 8'h07, 3, offs_07, 576 + 64 * PB);
    send_single("x03", 8'h03, 3, offs_03, 576 + 64 * PB);

    // Back-to-back 00 then FF.
    @(posedge clk);
    #5;
    clear_trackers();
    fifo.push_back(8'h00);
    fifo.push_back(8'hFF);
    wait_busy_fall("b2b");
    repeat (4) @(posedge clk);
    #5;
    p  = edge_at(1);
    s2 = edge_at(2);
    chk("b2b_pops", 32'(rd_cnt), 32'd2);
    chk("b2b_stop_gap", 32'(s2 - p), 32'd66);
    chk("b2b_pop2", 32'(rd_at(1) - p), 32'd65);
    chk("b2b_start2_len", 32'(edge_at(3) - s2), 32'd62);
    chk("b2b_baud_gap", 32'(baud_gap), 32'd0);
    chk("b2b_busy_end", 32'(busy_fall - s2), 32'(62 + (9 + PB) * 64));

    // Reset in the middle of data bit 3 of 8'h3C.
    @(posedge clk);
    #5;
    clear_trackers();
    fifo.push_back(8'h3C);
    wait_edges("rst3c", 2);
    repeat (96) @(posedge clk);
    #3;
    chk("rst3c_busy_before", 32'(tx_busy), 32'd1);
    chk("rst3c_baud_before", 32'(baud_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst3c_tx", 32'(tx_data), 32'd1);
    chk("rst3c_busy", 32'(tx_busy), 32'd0);
    chk("rst3c_baud_en", 32'(baud_en), 32'd0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    clear_trackers();
    repeat (200) @(posedge clk);
    #5;
    chk("rst3c_no_pop", 32'(rd_cnt), 32'd0);
    chk("rst3c_idle_tx", 32'(tx_data), 32'd1);

    // Reset during the start bit drops the line high at once.
    clear_trackers();
    fifo.push_back(8'h81);
    wait_edges("rst_start", 1);
    repeat (10) @(posedge clk);
    #3;
    chk("rst_start_low", 32'(tx_data), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_start_tx", 32'(tx_data), 32'd1);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (50) @(posedge clk);
    #5;

    // Two stop bits, two frames of 8'h55 back-to-back.
    edges2.delete();
    rd2_cnt    = 0;
    busy2_fall = -1;
    ff_empty2  = 1'b0;
    n = 0;
    while (rd2_cnt < 2 && n < 4000) begin
      @(posedge clk);
      #5;
      n++;
    end
    chk("sb2_pop_timeout", 32'(rd2_cnt >= 2), 32'd1);
    ff_empty2 = 1'b1;
    n = 0;
    while (busy2_fall < 0 && n < 4000) begin
      @(posedge clk);
      n++;
    end
    chk("sb2_busy_timeout", 32'(busy2_fall >= 0), 32'd1);
    repeat (4) @(posedge clk);
    #5;
    chk("sb2_pops", 32'(rd2_cnt), 32'd2);
    chk("sb2_edge_cnt", 32'(edges2.size()), 32'd20);
    chk("sb2_stop_gap", 32'(edge2_at(10) - edge2_at(9)), 32'd130);
    chk("sb2_stop_end", 32'(busy2_fall - edge2_at(19)), 32'd128);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
